sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Two-master to one-slave Avalon-MM arbiter that shares a single 64-bit f2h_sdram port (for example, ram1 of sysmem_lite) between two core-side requesters, A and B. It grants whole bursts with round-robin fairness. A burst keeps ownership until its last write beat is accepted or its last read beat is returned. It sits in the ramclk domain, directly in front of the HPS SDRAM port.

## Interface
Parameters:
- AW, 29, address width (word address, matches f2h_sdram1/2)
- DW, 64, data width; byteenable width is DW/8
- BW, 8, burstcount width

Ports (x = a, b; both masters have identical port sets):
- ramclk_clk  in  1  sole clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- x_address  in  AW  master word address
- x_burstcount  in  BW  burst length in beats; 0 is treated as 1
- x_read  in  1  read command
- x_write  in  1  write command or write beat
- x_writedata  in  DW  write data
- x_byteenable  in  DW/8  write byte lanes
- x_waitrequest  out  1  stall to master
- x_readdata  out  DW  read data (shared bus, broadcast to both masters)
- x_readdatavalid  out  1  read beat valid, asserted to the owning master only
- ram_address, ram_burstcount, ram_read, ram_write, ram_writedata, ram_byteenable  out  –  to SDRAM port
- ram_waitrequest, ram_readdata, ram_readdatavalid  in  –  from SDRAM port
- grant  out  2  one-hot current owner ({b,a}); 00 when idle
- rd_orphan  out  1  one-cycle pulse on a readdatavalid that has no owner

## Operation
- State machine: IDLE, WR_BURST, RD_CMD, RD_DATA.
- Registers: state, owner (a/b), last_owner, beats_left (BW bits).
- IDLE:
  - req_x = x_read | x_write.
  - If only one master requests, grant it.
  - If both request, grant the master that is not last_owner.
  - A master asserting write goes to WR_BURST; otherwise it goes to RD_CMD. If read and write are both asserted, write wins.
  - No request: stay in IDLE.
- Command path: in non-IDLE states, the ram_* command outputs are a mux of the owner's inputs.
  - ram_read is forced to 0 outside RD_CMD.
  - ram_write is forced to 0 outside WR_BURST.
  - In IDLE, ram_* outputs are 0.
- x_waitrequest:
  - For the owner in WR_BURST and RD_CMD: equals ram_waitrequest.
  - In all other cases: 1.
- WR_BURST:
  - A beat is accepted when ram_write & !ram_waitrequest.
  - On the first accepted beat, beats_left = max(burstcount,1) - 1; each later accepted beat decrements it.
  - The burst ends on the beat accepted with beats_left==0 (a first beat counts when max(burstcount,1)==1). The FSM then goes to IDLE and last_owner <= owner.
  - If the owner deasserts write between beats, ownership is kept (no timeout).
- RD_CMD:
  - On acceptance (ram_read & !ram_waitrequest): beats_left = max(burstcount,1); go to RD_DATA.
- RD_DATA:
  - ram_read is 0, and both x_waitrequest are 1.
  - owner_readdatavalid = ram_readdatavalid.
  - Each valid beat decrements beats_left. The beat that brings it from 1 to 0 sends the FSM to IDLE and sets last_owner <= owner.
  - At most one read burst is outstanding at any time.
- ram_readdatavalid outside RD_DATA: dropped (neither master sees it), and rd_orphan pulses.
- grant is decoded from state and owner.

## Timing
- Reset values: state=IDLE, last_owner=b (so A wins the first tie), beats_left=0, grant=00, both x_waitrequest=1, both x_readdatavalid=0, ram_read=ram_write=0, rd_orphan=0.
- Reset mid-burst returns to IDLE immediately. Read beats still in flight after reset are reported via rd_orphan and are not forwarded.
- Arbitration latency: a request sampled in IDLE at edge N puts the command on ram_* from cycle N+1.
- One IDLE bubble separates consecutive bursts (the last beat accepted at edge E is followed by the next grant at E+1).
- Combinational paths: ram_waitrequest → x_waitrequest and ram_readdata/ram_readdatavalid → x_* are combinational. All other outputs are registered state decodes or muxes.
- beats_left never underflows: a decrement at 0 cannot occur in a legal sequence, and decrements are gated at 0.
- A simultaneous request from the non-owner during a burst is held off by waitrequest=1 until the next IDLE.

## Test plan
- A and B both raise a 4-beat write in the same cycle after reset → A is granted first (grant=01) for 4 accepted beats, then one IDLE cycle, then B (grant=10); ram sees 8 beats in order A0..A3, B0..B3.
- A issues a read with burstcount=8; ram returns 8 readdatavalid with waitrequest held 2 cycles on the command → a_readdatavalid pulses 8 times, b_readdatavalid stays 0, and the FSM returns to IDLE after the 8th beat.
- A requests continuously (1-beat writes) while B requests once → grants alternate A, B, A, and B is served within 2 bursts.
- A write with burstcount=0 → treated as 1 beat; the FSM leaves WR_BURST after a single accepted beat.
- Deassert rst_n during RD_DATA after 3 of 8 beats, release, and the ram supplies the remaining 5 → all outputs are at reset values during reset, rd_orphan pulses 5 times, and no x_readdatavalid is asserted.
- A write burst where the master deasserts write for 3 cycles mid-burst while B requests → grant stays 01 until A's final beat is accepted.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one 64-bit f2h_sdram Avalon-MM port between two core-side masters (A, B).
// Whole bursts are granted with round-robin fairness. Ownership is held until the
// last write beat is accepted or the last read beat comes back. Single clock domain
// (ramclk).

module sdram_port_arbiter #(
    parameter int AW = 29,
    parameter int DW = 64,
    parameter int BW = 8
) (
    input  logic              ramclk_clk,
    input  logic              rst_n,

    input  logic [AW-1:0]     a_address,
    input  logic [BW-1:0]     a_burstcount,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DW-1:0]     a_writedata,
    input  logic [DW/8-1:0]   a_byteenable,
    output logic              a_waitrequest,
    output logic [DW-1:0]     a_readdata,
    output logic              a_readdatavalid,

    input  logic [AW-1:0]     b_address,
    input  logic [BW-1:0]     b_burstcount,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DW-1:0]     b_writedata,
    input  logic [DW/8-1:0]   b_byteenable,
    output logic              b_waitrequest,
    output logic [DW-1:0]     b_readdata,
    output logic              b_readdatavalid,

    output logic [AW-1:0]     ram_address,
    output logic [BW-1:0]     ram_burstcount,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DW-1:0]     ram_writedata,
    output logic [DW/8-1:0]   ram_byteenable,
    input  logic              ram_waitrequest,
    input  logic [DW-1:0]     ram_readdata,
    input  logic              ram_readdatavalid,

    output logic [1:0]        grant,
    output logic              rd_orphan
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    // owner / last_owner encoding: 0 = master A, 1 = master B
    state_t          state;
    logic            owner;
    logic            last_owner;
    logic [BW-1:0]   beats_left;
    logic            wr_first;

    logic            req_a;
    logic            req_b;
    logic            pick_b;
    logic            pick_write;

    logic [AW-1:0]   own_address;
    logic [BW-1:0]   own_burstcount;
    logic            own_read;
    logic            own_write;
    logic [DW-1:0]   own_writedata;
    logic [DW/8-1:0] own_byteenable;
    logic [BW-1:0]   eff_burst;

    logic            cmd_phase;
    logic            wr_accept;
    logic            rd_accept;

    // Round-robin pick among requesters; on a tie the master that did not go last wins
    always_comb begin
        req_a      = a_read | a_write;
        req_b      = b_read | b_write;
        pick_b     = req_b & (~req_a | (last_owner == 1'b0));
        pick_write = pick_b ? b_write : a_write;
    end

    // Select the current owner's command inputs; a burstcount of 0 counts as one beat
    always_comb begin
        own_address    = owner ? b_address    : a_address;
        own_burstcount = owner ? b_burstcount : a_burstcount;
        own_read       = owner ? b_read       : a_read;
        own_write      = owner ? b_write      : a_write;
        own_writedata  = owner ? b_writedata  : a_writedata;
        own_byteenable = owner ? b_byteenable : a_byteenable;
        eff_burst      = (own_burstcount == '0) ? BW'(1) : own_burstcount;
    end

    // Drive the SDRAM command bus from the owner, quiet while idle
    always_comb begin
        ram_address    = '0;
        ram_burstcount = '0;
        ram_writedata  = '0;
        ram_byteenable = '0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        if (state != IDLE) begin
            ram_address    = own_address;
            ram_burstcount = own_burstcount;
            ram_writedata  = own_writedata;
            ram_byteenable = own_byteenable;
            ram_read       = (state == RD_CMD)   & own_read;
            ram_write      = (state == WR_BURST) & own_write;
        end
    end

    // Stall everyone except the owner during its command phase; route read beats to the owner
    always_comb begin
        cmd_phase       = (state == WR_BURST) || (state == RD_CMD);
        wr_accept       = ram_write & ~ram_waitrequest;
        rd_accept       = ram_read  & ~ram_waitrequest;
        a_waitrequest   = (cmd_phase && (owner == 1'b0)) ? ram_waitrequest : 1'b1;
        b_waitrequest   = (cmd_phase && (owner == 1'b1)) ? ram_waitrequest : 1'b1;
        a_readdata      = ram_readdata;
        b_readdata      = ram_readdata;
        a_readdatavalid = (state == RD_DATA) && (owner == 1'b0) && ram_readdatavalid;
        b_readdatavalid = (state == RD_DATA) && (owner == 1'b1) && ram_readdatavalid;
        grant           = 2'b00;
        if (state != IDLE) begin
            grant = owner ? 2'b10 : 2'b01;
        end
    end

    // Burst ownership state machine with beat counting
    always_ff @(posedge ramclk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            beats_left <= '0;
            wr_first   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        owner    <= pick_b;
                        wr_first <= 1'b1;
                        state    <= pick_write ? WR_BURST : RD_CMD;
                    end
                end
                WR_BURST: begin
                    if (wr_accept) begin
                        if (wr_first) begin
                            wr_first <= 1'b0;
                            if (eff_burst == BW'(1)) begin
                                beats_left <= '0;
                                last_owner <= owner;
                                state      <= IDLE;
                            end else begin
                                beats_left <= eff_burst - BW'(1);
                            end
                        end else begin
                            if (beats_left != '0) begin
                                beats_left <= beats_left - BW'(1);
                            end
                            if (beats_left <= BW'(1)) begin
                                last_owner <= owner;
                                state      <= IDLE;
                            end
                        end
                    end
                end
                RD_CMD: begin
                    if (rd_accept) begin
                        beats_left <= eff_burst;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (ram_readdatavalid) begin
                        if (beats_left != '0) begin
                            beats_left <= beats_left - BW'(1);
                        end
                        if (beats_left <= BW'(1)) begin
                            last_owner <= owner;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flag read beats that arrive while no read burst owns the return path
    always_ff @(posedge ramclk_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_orphan <= 1'b0;
        end else begin
            rd_orphan <= ram_readdatavalid && (state != RD_DATA);
        end
    end

endmodule
